div_bus_master: RTL and testbench

- Bus initiator that drives the calculator SoC peripheral bus (cs/addr/rd/wr/data) to run one 8-bit division on the divider peripheral.
- Accepts an operand pair from the calculator control logic over a valid/ready handshake, then writes the operands and polls the peripheral status.
- When the peripheral reports completion, reads the quotient and remainder and returns them with error flags.
- Sits between the calculator sequencer and the divider peripheral's bus port.

---
 rtl/div_bus_master.sv | 207 ++++++++++++++++++++
 tb/tb_div_bus_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_bus_master.sv
// Bus initiator that runs one 8-bit division on the divider peripheral:
// writes {B,A}, polls status with a fixed gap, then reads quotient and remainder.
module div_bus_master #(
    parameter int unsigned POLL_GAP  = 2,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [4:0]  ADDR_OPS  = 5'h00,
    parameter logic [4:0]  ADDR_STAT = 5'h04,
    parameter logic [4:0]  ADDR_REM  = 5'h08
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [7:0]  resp_q,
    output logic [7:0]  resp_r,
    output logic        resp_dz,
    output logic        resp_to,
    output logic        cs,
    output logic [4:0]  addr,
    output logic        rd,
    output logic        wr,
    output logic [15:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned GAP_CYC  = (POLL_GAP == 0) ? 1 : POLL_GAP;
    localparam logic [3:0]  GAP_LAST = 4'(GAP_CYC - 1);
    localparam logic [7:0]  POLL_MAX = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_POLL,
        S_RD_Q,
        S_RD_R,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic [7:0]  poll_inc;
    logic        cs_q, cs_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] bus_wdata_q, bus_wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [7:0]  resp_q_q, resp_q_d;
    logic [7:0]  resp_r_q, resp_r_d;
    logic        resp_dz_q, resp_dz_d;
    logic        resp_to_q, resp_to_d;

    // Only the low byte of read data carries results.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^bus_rdata[31:8];

    // State and output registers; reset drops every bus strobe on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            gap_cnt_q    <= '0;
            poll_cnt_q   <= '0;
            cs_q         <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            bus_wdata_q  <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_q_q     <= '0;
            resp_r_q     <= '0;
            resp_dz_q    <= 1'b0;
            resp_to_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            poll_cnt_q   <= poll_cnt_d;
            cs_q         <= cs_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            bus_wdata_q  <= bus_wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_q_q     <= resp_q_d;
            resp_r_q     <= resp_r_d;
            resp_dz_q    <= resp_dz_d;
            resp_to_q    <= resp_to_d;
        end
    end

    // Next state; bus outputs are computed for the state being entered.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        poll_cnt_d   = poll_cnt_q;
        poll_inc     = poll_cnt_q + 8'd1;
        cs_d         = 1'b0;
        rd_d         = 1'b0;
        wr_d         = 1'b0;
        addr_d       = '0;
        bus_wdata_d  = bus_wdata_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_q_d     = resp_q_q;
        resp_r_d     = resp_r_q;
        resp_dz_d    = resp_dz_q;
        resp_to_d    = resp_to_q;

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    bus_wdata_d = {op_b, op_a};
                    poll_cnt_d  = '0;
                    resp_q_d    = '0;
                    resp_r_d    = '0;
                    resp_dz_d   = 1'b0;
                    resp_to_d   = 1'b0;
                    req_ready_d = 1'b0;
                    cs_d        = 1'b1;
                    wr_d        = 1'b1;
                    addr_d      = ADDR_OPS;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                gap_cnt_d = GAP_LAST;
                state_d   = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    cs_d    = 1'b1;
                    rd_d    = 1'b1;
                    addr_d  = ADDR_STAT;
                    state_d = S_POLL;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            S_POLL: begin
                // done wins over timeout on the same poll
                if (bus_rdata[1]) begin
                    resp_dz_d = bus_rdata[2];
                    cs_d      = 1'b1;
                    rd_d      = 1'b1;
                    addr_d    = ADDR_OPS;
                    state_d   = S_RD_Q;
                end else begin
                    poll_cnt_d = poll_inc;
                    if (poll_inc == POLL_MAX) begin
                        resp_to_d = 1'b1;
                        resp_q_d  = '0;
                        resp_r_d  = '0;
                        state_d   = S_RESP;
                    end else begin
                        gap_cnt_d = GAP_LAST;
                        state_d   = S_GAP;
                    end
                end
            end
            S_RD_Q: begin
                resp_q_d = bus_rdata[7:0];
                cs_d     = 1'b1;
                rd_d     = 1'b1;
                addr_d   = ADDR_REM;
                state_d  = S_RD_R;
            end
            S_RD_R: begin
                resp_r_d = bus_rdata[7:0];
                state_d  = S_RESP;
            end
            S_RESP: begin
                resp_valid_d = 1'b1;
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_q     = resp_q_q;
    assign resp_r     = resp_r_q;
    assign resp_dz    = resp_dz_q;
    assign resp_to    = resp_to_q;
    assign cs         = cs_q;
    assign rd         = rd_q;
    assign wr         = wr_q;
    assign addr       = addr_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_div_bus_master.sv
// Bench for div_bus_master: behavioural divider peripheral, bus monitor and a
// transaction-level expectation model driven by random and directed requests.
module tb_div_bus_master;

    localparam int unsigned TO     = 4;
    localparam logic [4:0]  A_OPS  = 5'h00;
    localparam logic [4:0]  A_STAT = 5'h04;
    localparam logic [4:0]  A_REM  = 5'h08;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  op_a = 8'd0;
    logic [7:0]  op_b = 8'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [7:0]  resp_q, resp_r;
    logic        resp_dz, resp_to;
    logic        cs, rd, wr;
    logic [4:0]  addr;
    logic [15:0] bus_wdata;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    div_bus_master #(
        .POLL_GAP(2), .TIMEOUT(TO),
        .ADDR_OPS(A_OPS), .ADDR_STAT(A_STAT), .ADDR_REM(A_REM)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .op_a(op_a), .op_b(op_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_q(resp_q), .resp_r(resp_r), .resp_dz(resp_dz), .resp_to(resp_to),
        .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    // Divider peripheral: done appears cfg_lat cycles after the write cycle.
    int          cfg_lat = 1;
    bit          cfg_never = 1'b0;
    logic [23:0] junk = 24'h0;
    logic [7:0]  pa = 8'd0, pb = 8'd0;
    int          pcnt = 0;
    logic        pstarted = 1'b0;
    logic        pdone;
    logic [7:0]  pq, pr;

    always @(posedge clk) begin
        if (cs && wr) begin
            pa       <= bus_wdata[7:0];
            pb       <= bus_wdata[15:8];
            pcnt     <= cfg_lat - 1;
            pstarted <= 1'b1;
        end else if (pcnt > 0) begin
            pcnt <= pcnt - 1;
        end
    end

    assign pdone = pstarted && (pcnt == 0) && !cfg_never;
    assign pq    = (pb == 8'd0) ? 8'hFF : pa / pb;
    assign pr    = (pb == 8'd0) ? pa : pa % pb;

    always_comb begin
        bus_rdata = 32'h0;
        if (cs && rd) begin
            case (addr)
                A_STAT:  bus_rdata = {29'd0, pb == 8'd0, pdone, pstarted && !pdone};
                A_OPS:   bus_rdata = {junk, pq};
                A_REM:   bus_rdata = {junk, pr};
                default: bus_rdata = 32'hDEAD_BEEF;
            endcase
        end
    end

    // Bus monitor: transfer counts, protocol violations and poll spacing.
    int          cyc = 0;
    int          wr_n = 0, st_n = 0, q_n = 0, r_n = 0;
    int          proto_err = 0, gap_err = 0;
    int          last_st = -1;
    logic [15:0] last_wdata = 16'h0;
    logic        proto_bad;

    assign proto_bad = (rd && wr) || ((rd || wr) && !cs) || (cs && !(rd || wr)) ||
                       (cs && wr && addr != A_OPS) ||
                       (cs && rd && addr != A_OPS && addr != A_STAT && addr != A_REM);

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            last_st <= -1;
        end else begin
            if (proto_bad) proto_err <= proto_err + 1;
            if (cs && wr) begin
                wr_n       <= wr_n + 1;
                last_wdata <= bus_wdata;
                last_st    <= -1;
            end
            if (cs && rd && addr == A_STAT) begin
                st_n    <= st_n + 1;
                last_st <= cyc;
                if (last_st >= 0 && cyc - last_st != 3) gap_err <= gap_err + 1;
            end
            if (cs && rd && addr == A_OPS) q_n <= q_n + 1;
            if (cs && rd && addr == A_REM) r_n <= r_n + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full request/response; expectations come from poll arithmetic:
    // poll k lands 3k cycles after the write, done is seen once 3k >= lat.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int lat,
                           input bit never, input int hold);
        int k, exp_st, exp_lat, n, w0, s0, q0, r0;
        bit to;
        logic [7:0] eq, er;
        k = (lat + 2) / 3;
        if (k < 1) k = 1;
        to      = never || (k > int'(TO));
        exp_st  = to ? int'(TO) : k;
        exp_lat = to ? 3 * int'(TO) + 2 : 3 * k + 4;
        eq = to ? 8'd0 : ((b == 8'd0) ? 8'hFF : a / b);
        er = to ? 8'd0 : ((b == 8'd0) ? a : a % b);
        cfg_lat   = lat;
        cfg_never = never;
        junk      = 24'($urandom);
        w0 = wr_n; s0 = st_n; q0 = q_n; r0 = r_n;

        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        op_a = a;
        op_b = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        op_a = 8'($urandom);
        op_b = 8'($urandom);
        check_eq("req_ready_busy", 32'(req_ready), 32'd0);
        n = 0;
        while (!resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("resp_valid_seen", 32'(resp_valid), 32'd1);
        if (!resp_valid) return;
        check_eq("latency", 32'(n), 32'(exp_lat));
        check_eq("resp_q", 32'(resp_q), 32'(eq));
        check_eq("resp_r", 32'(resp_r), 32'(er));
        check_eq("resp_dz", 32'(resp_dz), 32'(!to && b == 8'd0));
        check_eq("resp_to", 32'(resp_to), 32'(to));

        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            op_a = 8'($urandom);
            op_b = 8'($urandom);
            @(negedge clk);
            check_eq("bp_valid", 32'(resp_valid), 32'd1);
            check_eq("bp_req_ready", 32'(req_ready), 32'd0);
            check_eq("bp_stable", {14'd0, resp_to, resp_dz, resp_q, resp_r},
                     {14'd0, to, !to && b == 8'd0, eq, er});
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq("resp_dropped", 32'(resp_valid), 32'd0);
        check_eq("req_ready_back", 32'(req_ready), 32'd1);
        check_eq("wr_count", 32'(wr_n - w0), 32'd1);
        check_eq("wdata", 32'(last_wdata), {16'd0, b, a});
        check_eq("stat_reads", 32'(st_n - s0), 32'(exp_st));
        check_eq("q_reads", 32'(q_n - q0), to ? 32'd0 : 32'd1);
        check_eq("r_reads", 32'(r_n - r0), to ? 32'd0 : 32'd1);
        check_eq("proto", 32'(proto_err), 32'd0);
        check_eq("poll_gap", 32'(gap_err), 32'd0);
    endtask

    // Reset asserted during a status poll aborts the transaction.
    task automatic reset_in_poll();
        int n;
        cfg_lat   = 1;
        cfg_never = 1'b1;
        req_valid = 1'b1;
        op_a = 8'd9;
        op_b = 8'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(cs && rd && addr == A_STAT) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("poll_reached", 32'(cs && rd && addr == A_STAT), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_bus", {29'd0, cs, rd, wr}, 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_idle", {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_bus", {27'd0, cs, rd, wr, addr == 5'd0, bus_wdata == 16'd0}, 32'd3);
        check_eq("reset_resp", {20'd0, resp_valid, resp_to, resp_dz, resp_q == 8'd0, resp_r == 8'd0, req_ready},
                 32'h7);
        reset = 1'b1;
        @(negedge clk);

        run_txn(8'd100, 8'd7, 8, 1'b0, 0);
        run_txn(8'd5, 8'd0, 2, 1'b0, 2);
        run_txn(8'd33, 8'd4, 1, 1'b0, 0);
        run_txn(8'd200, 8'd9, 12, 1'b0, 1);
        run_txn(8'd50, 8'd5, 13, 1'b0, 0);
        run_txn(8'd77, 8'd3, 1, 1'b1, 0);
        run_txn(8'd255, 8'd16, 4, 1'b0, 10);
        reset_in_poll();
        run_txn(8'd42, 8'd6, 3, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_txn(a, b, int'($urandom_range(1, 15)), $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
